// File: rtl/an_pkg.sv
// Shared constants, state encoding and residue table for the A=47 AN-code decoder.
package an_pkg;

    localparam int A       = 47;
    localparam int CW_W    = 23;
    localparam int N_W     = 17;
    localparam int RESID_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        RESID,
        CORR,
        DIV,
        DONE
    } state_t;

    // Entry k is 2^k mod 47; 2 has order 23, so the table and its negatives cover every nonzero residue.
    localparam logic [RESID_W-1:0] POW2_MOD_A [CW_W] = '{
        6'd1,  6'd2,  6'd4,  6'd8,  6'd16, 6'd32, 6'd17, 6'd34,
        6'd21, 6'd42, 6'd37, 6'd27, 6'd7,  6'd14, 6'd28, 6'd9,
        6'd18, 6'd36, 6'd25, 6'd3,  6'd6,  6'd12, 6'd24
    };

endpackage

// File: rtl/an_syndrome_lut.sv
// Maps a residue to the single +/-2^k error that produces it.
module an_syndrome_lut
    import an_pkg::*;
(
    input  logic [RESID_W-1:0] r,
    output logic               hit,
    output logic [4:0]         k,
    output logic               neg
);

    // Residue A - (2^k mod A) means 2^k was lost, i.e. the received word is too small.
    always_comb begin
        hit = 1'b0;
        k   = '0;
        neg = 1'b0;
        for (int i = 0; i < CW_W; i++) begin
            if (r == POW2_MOD_A[i]) begin
                hit = 1'b1;
                k   = 5'(i);
                neg = 1'b0;
            end else if (r == RESID_W'(A) - POW2_MOD_A[i]) begin
                hit = 1'b1;
                k   = 5'(i);
                neg = 1'b1;
            end
        end
    end

endmodule

// File: rtl/an_decode_ctrl.sv
// Bit-serial AN-code single-error decoder: residue, syndrome correction, restoring division by A.
// Optional BER counters (cnt_clr, corr_cnt, uncorr_cnt) are built when ANDEC_ERR_CNT_EN is defined.
module an_decode_ctrl #(
    parameter int A    = an_pkg::A,
    parameter int CW_W = an_pkg::CW_W,
    parameter int N_W  = an_pkg::N_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW_W-1:0] in_ane,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N_W-1:0]  out_n,
    output logic            out_corr,
    output logic            out_uncorr,
    output logic [4:0]      out_err_pos,
    output logic            out_err_neg
`ifdef ANDEC_ERR_CNT_EN
    ,
    input  logic            cnt_clr,
    output logic [15:0]     corr_cnt,
    output logic [15:0]     uncorr_cnt
`endif
);

    localparam int RW = an_pkg::RESID_W;

    an_pkg::state_t state, state_next;

    logic [CW_W-1:0] value;
    logic [RW-1:0]   r;
    logic [4:0]      cnt;
    logic            corr_q;
    logic            uncorr_q;
    logic            neg_q;
    logic [4:0]      pos_q;

    logic            lut_hit;
    logic [4:0]      lut_k;
    logic            lut_neg;

    logic [RW:0]     r_shift;
    logic            r_ge;
    logic [RW-1:0]   r_step;
    logic [CW_W:0]   pow;
    logic [CW_W:0]   sum;

    an_syndrome_lut u_lut (
        .r   (r),
        .hit (lut_hit),
        .k   (lut_k),
        .neg (lut_neg)
    );

    // One mod-A step shared by the residue pass and the division pass; r_ge doubles as the quotient bit.
    always_comb begin
        r_shift = {r, value[CW_W-1]};
        r_ge    = (r_shift >= (RW+1)'(A));
        r_step  = r_ge ? RW'(r_shift - (RW+1)'(A)) : RW'(r_shift);
        pow     = (CW_W+1)'(1) << lut_k;
        if (r == '0) begin
            sum = {1'b0, value};
        end else if (!lut_neg) begin
            sum = {1'b0, value} - pow;
        end else begin
            sum = {1'b0, value} + pow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= an_pkg::IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            an_pkg::IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = an_pkg::RESID;
                end
            end
            an_pkg::RESID: begin
                if (cnt == 5'(CW_W - 1)) begin
                    state_next = an_pkg::CORR;
                end
            end
            an_pkg::CORR: begin
                state_next = an_pkg::DIV;
            end
            an_pkg::DIV: begin
                if (cnt == 5'(CW_W)) begin
                    state_next = an_pkg::DONE;
                end
            end
            an_pkg::DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = an_pkg::IDLE;
                end
            end
            default: begin
                state_next = an_pkg::IDLE;
            end
        endcase
    end

    // The residue pass rotates value so the codeword is intact again when CORR needs it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value    <= '0;
            r        <= '0;
            cnt      <= '0;
            corr_q   <= 1'b0;
            uncorr_q <= 1'b0;
            neg_q    <= 1'b0;
            pos_q    <= '0;
        end else begin
            case (state)
                an_pkg::IDLE: begin
                    if (in_valid) begin
                        value    <= in_ane;
                        r        <= '0;
                        cnt      <= '0;
                        corr_q   <= 1'b0;
                        uncorr_q <= 1'b0;
                        neg_q    <= 1'b0;
                        pos_q    <= '0;
                    end
                end
                an_pkg::RESID: begin
                    value <= {value[CW_W-2:0], value[CW_W-1]};
                    r     <= r_step;
                    cnt   <= (cnt == 5'(CW_W - 1)) ? '0 : cnt + 5'd1;
                end
                an_pkg::CORR: begin
                    value    <= sum[CW_W-1:0];
                    uncorr_q <= sum[CW_W] | ((r != '0) & ~lut_hit);
                    corr_q   <= (r != '0) & lut_hit;
                    neg_q    <= (r != '0) & lut_hit & lut_neg;
                    pos_q    <= ((r != '0) & lut_hit) ? lut_k : '0;
                    r        <= '0;
                    cnt      <= '0;
                end
                an_pkg::DIV: begin
                    if (cnt != 5'(CW_W)) begin
                        value <= {value[CW_W-2:0], r_ge};
                        r     <= r_step;
                        cnt   <= cnt + 5'd1;
                    end else begin
                        uncorr_q <= uncorr_q | (value[CW_W-1:N_W] != '0) | (r != '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_uncorr  = uncorr_q;
    assign out_n       = uncorr_q ? '0 : value[N_W-1:0];
    assign out_corr    = corr_q & ~uncorr_q;
    assign out_err_pos = uncorr_q ? '0 : pos_q;
    assign out_err_neg = neg_q & ~uncorr_q;

`ifdef ANDEC_ERR_CNT_EN
    logic out_fire;
    assign out_fire = out_valid & out_ready;

    // Clear takes priority over a coinciding handshake; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_fire) begin
            if (out_corr && corr_cnt != 16'hFFFF) begin
                corr_cnt <= corr_cnt + 16'd1;
            end
            if (out_uncorr && uncorr_cnt != 16'hFFFF) begin
                uncorr_cnt <= uncorr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_an_decode_ctrl.sv
// Scoreboard bench for an_decode_ctrl: directed codewords with hand-computed results.
module tb_an_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [22:0] in_ane = '0;
    logic        in_ready;
    logic        out_valid;
    logic [16:0] out_n;
    logic        out_corr;
    logic        out_uncorr;
    logic [4:0]  out_err_pos;
    logic        out_err_neg;
`ifdef ANDEC_ERR_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;
`endif

    typedef struct {
        logic [22:0] ane;
        logic [16:0] n;
        logic        corr;
        logic        uncorr;
        logic [4:0]  pos;
        logic        neg;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    an_decode_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ane      (in_ane),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_n       (out_n),
        .out_corr    (out_corr),
        .out_uncorr  (out_uncorr),
        .out_err_pos (out_err_pos),
        .out_err_neg (out_err_neg)
`ifdef ANDEC_ERR_CNT_EN
        ,
        .cnt_clr     (cnt_clr),
        .corr_cnt    (corr_cnt),
        .uncorr_cnt  (uncorr_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drives one codeword, records its expected result and the edge on which it is accepted.
    task automatic applyStimulus(input logic [22:0] ane, input logic [16:0] n, input logic corr,
                                 input logic uncorr, input logic [4:0] pos, input logic neg);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        in_ane   = ane;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        e = '{ane, n, corr, uncorr, pos, neg, cyc + 1};
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compares every new result against the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput($sformatf("n[%0d]", e.ane), out_n, e.n);
                    checkOutput($sformatf("corr[%0d]", e.ane), out_corr, e.corr);
                    checkOutput($sformatf("uncorr[%0d]", e.ane), out_uncorr, e.uncorr);
                    checkOutput($sformatf("pos[%0d]", e.ane), out_err_pos, e.pos);
                    checkOutput($sformatf("neg[%0d]", e.ane), out_err_neg, e.neg);
                    checkOutput($sformatf("latency[%0d]", e.ane), cyc - e.acc, 32'd48);
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int waited;

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 32'd1);
        checkOutput("rst_out_valid", out_valid, 32'd0);
        checkOutput("rst_out_n", out_n, 32'd0);
        checkOutput("rst_out_corr", out_corr, 32'd0);
        checkOutput("rst_out_uncorr", out_uncorr, 32'd0);
        checkOutput("rst_out_err_pos", out_err_pos, 32'd0);
        checkOutput("rst_out_err_neg", out_err_neg, 32'd0);
        rst_n = 1'b1;

        applyStimulus(23'd57011,   17'd1213, 1'b0, 1'b0, 5'd0,  1'b0);
        applyStimulus(23'd57015,   17'd1213, 1'b1, 1'b0, 5'd2,  1'b0);
        applyStimulus(23'd4251315, 17'd1213, 1'b1, 1'b0, 5'd22, 1'b0);
        applyStimulus(23'd57010,   17'd1213, 1'b1, 1'b0, 5'd0,  1'b1);
        applyStimulus(23'd24243,   17'd1213, 1'b1, 1'b0, 5'd15, 1'b1);
        applyStimulus(23'd8388607, 17'd0,    1'b0, 1'b1, 5'd0,  1'b0);
        applyStimulus(23'd1,       17'd0,    1'b1, 1'b0, 5'd0,  1'b0);
        drain();

        // Backpressure: hold DONE for 10 cycles while a second word waits.
        out_ready = 1'b0;
        applyStimulus(23'd57015, 17'd1213, 1'b1, 1'b0, 5'd2, 1'b0);
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("bp_valid_seen", out_valid, 32'd1);
        in_ane   = 23'd24243;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", out_valid, 32'd1);
            checkOutput("bp_hold_n", out_n, 32'd1213);
            checkOutput("bp_hold_pos", out_err_pos, 32'd2);
            checkOutput("bp_hold_corr", out_corr, 32'd1);
            checkOutput("bp_in_ready", in_ready, 32'd0);
        end
        out_ready = 1'b1;
        sb.push_back('{23'd24243, 17'd1213, 1'b1, 1'b0, 5'd15, 1'b1, cyc + 2});
        @(negedge clk);
        checkOutput("bp_after_hs_in_ready", in_ready, 32'd1);
        checkOutput("bp_after_hs_out_valid", out_valid, 32'd0);
        @(negedge clk);
        checkOutput("bp_second_accepted", in_ready, 32'd0);
        in_valid = 1'b0;
        drain();

        // Reset in the tenth RESID cycle aborts the word without emitting anything.
        @(negedge clk);
        in_ane   = 23'd57011;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("abort_busy", in_ready, 32'd0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", out_valid, 32'd0);
        checkOutput("abort_in_ready", in_ready, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("abort_no_output", out_valid, 32'd0);
        checkOutput("abort_idle", in_ready, 32'd1);

        applyStimulus(23'd57019, 17'd1213, 1'b1, 1'b0, 5'd3, 1'b0);
        drain();
`ifdef ANDEC_ERR_CNT_EN
        checkOutput("corr_cnt_after_reset", corr_cnt, 32'd1);
        checkOutput("uncorr_cnt_after_reset", uncorr_cnt, 32'd0);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checkOutput("corr_cnt_cleared", corr_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
